fpu_issue_ctrl: RTL

Sequencing stage that wraps the FPU arithmetic datapath. It accepts one FP operation at a time from the core's decode/execute stage over a valid/ready handshake, resolves dynamic rounding from `frm`, and drives the arithmetic unit's `start`/`op`/operand inputs until `done`. It then captures the result and exception flags, accrues flags into `fcsr`, and presents the result to writeback over a second valid/ready handshake.

---
 rtl/fpu_issue_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// FP issue/sequencing stage: one op at a time into the arithmetic unit, owns fflags/frm.
// Optional watchdog abort enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic        req_rs2_lsb,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rounding_mode,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    output logic        fpu_flush,
    input  logic [31:0] fpu_out,
    input  logic        fpu_done,
    input  logic        fpu_nv,
    input  logic        fpu_dz,
    input  logic        fpu_of,
    input  logic        fpu_uf,
    input  logic        fpu_nx,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        rsp_timeout,
    input  logic        csr_we,
    input  logic [1:0]  csr_sel,
    input  logic [7:0]  csr_wdata,
    output logic [7:0]  csr_rdata,
    output logic [2:0]  frm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        ill_q, ill_d;
    logic [4:0]  fflags_q, fflags_d;
    logic [2:0]  frm_q, frm_d;

    logic        is_rnd;
    logic [2:0]  rm_res;
    logic        rm_bad;
    logic [4:0]  cap;

`ifdef FPU_ISSUE_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        flush;
`endif

    // Dynamic rounding only applies to ops that actually round; others use rm as funct3.
    always_comb begin
        is_rnd = req_op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                5'b01011, 5'b11000, 5'b11010};
        rm_res = (is_rnd && req_rm == 3'b111) ? frm_q : req_rm;
        rm_bad = is_rnd && rm_res[2] && (rm_res[1:0] != 2'b00);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rm_d    = rm_q;
        a_d     = a_q;
        b_d     = b_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ill_d   = ill_q;
        cap     = 5'b00000;
`ifdef FPU_ISSUE_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        flush   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    rm_d    = rm_res;
                    a_d     = req_a;
                    b_d     = req_b;
                    rs2_d   = req_rs2_lsb;
                    rd_d    = req_rd;
                    data_d  = 32'h0;
                    ill_d   = rm_bad;
                    state_d = rm_bad ? RESP : EXEC;
`ifdef FPU_ISSUE_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    tmo_d   = 1'b0;
`endif
                end
            end
            EXEC: begin
                if (fpu_done) begin
                    data_d  = fpu_out;
                    cap     = {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx};
                    state_d = RESP;
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (cnt_q == 8'd254) begin
                    flush   = 1'b1;
                    data_d  = 32'h7FC0_0000;
                    tmo_d   = 1'b1;
                    cap     = 5'b10000;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A CSR write replaces fflags, but flags captured this cycle still land.
        if (csr_we && csr_sel[0]) fflags_d = csr_wdata[4:0] | cap;
        else                      fflags_d = fflags_q | cap;
        frm_d = (csr_we && csr_sel[1]) ? csr_wdata[7:5] : frm_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= 5'd0;
            rm_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rs2_q    <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            ill_q    <= 1'b0;
            fflags_q <= 5'd0;
            frm_q    <= 3'd0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q    <= 8'd0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rm_q     <= rm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            ill_q    <= ill_d;
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign fpu_start         = (state_q == EXEC);
    assign rsp_valid         = (state_q == RESP);
    assign fpu_op            = op_q;
    assign fpu_rounding_mode = rm_q;
    assign fpu_a             = a_q;
    assign fpu_b             = b_q;
    assign fpu_rs2_lsb       = rs2_q;
    assign rsp_data          = data_q;
    assign rsp_rd            = rd_q;
    assign rsp_illegal       = ill_q;
    assign frm               = frm_q;

`ifdef FPU_ISSUE_TIMEOUT_EN
    assign fpu_flush   = flush;
    assign rsp_timeout = tmo_q;
`else
    assign fpu_flush   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        unique case (csr_sel)
            2'b01:   csr_rdata = {3'b000, fflags_q};
            2'b10:   csr_rdata = {5'b00000, frm_q};
            2'b11:   csr_rdata = {frm_q, fflags_q};
            default: csr_rdata = 8'h00;
        endcase
    end

endmodule
